fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined RV32I core. It holds the program counter and drives the instruction-memory address. It predicts control flow with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters, and it contains the fetch→decode pipeline register. It sits directly upstream of the decode stage. It consumes branch/jump resolution from the execute stage and reports mispredicts to the hazard logic.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of PC, instruction and target fields.
- `BTB_ENTRIES`, 16, number of BTB entries; must be a power of two, ≥2. `IDX = log2(BTB_ENTRIES)`.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk` in 1: rising-edge clock for all state.
- `rst` in 1: synchronous, active-low reset (asserted when 0, sampled on `clk` rising edge).
- `StallF` in 1: hold PCF.
- `StallD` in 1: hold the decode register.
- `FlushD` in 1: load a bubble into the decode register.
- `InstrF` in 32: instruction word from instruction memory, combinational on `PCF`.
- `ResolveE` in 1: a branch/jump in execute resolved this cycle. Asserted for exactly one cycle per instruction.
- `PCE` in 32: PC of the resolving instruction.
- `TakenE` in 1: actual outcome (jumps always 1).
- `TargetE` in 32: actual target address.
- `PredTakenE` in 1: prediction carried down the pipe for that instruction.
- `PredTargetE` in 32: predicted target carried down the pipe.
- `PCF` out 32: current fetch address to instruction memory.
- `InstrD` out 32: instruction to decode.
- `PCD` out 32: PC of `InstrD`.
- `PCPlus4D` out 32: `PCD + 4`.
- `PredTakenD` out 1: prediction for `InstrD`.
- `PredTargetD` out 32: predicted target for `InstrD`.
- `MispredictE` out 1: combinational; execute-stage redirect required. The hazard logic uses it to flush execute.

## Operation
- BTB entry fields: `valid`, `tag = PC[31:IDX+2]`, `target[31:0]`, and `ctr[1:0]`.
- Lookup index is `PCF[IDX+1:2]`.
- Hit condition: `valid` is set and `tag` matches.
- Predict taken when the lookup hits and `ctr[1]==1`. The predicted target is then the entry's `target`.
- Mispredict condition: `MispredictE = ResolveE & ((TakenE != PredTakenE) | (TakenE & (TargetE != PredTargetE)))`.
- PCNext priority, highest first:
  1. Mispredict: `TakenE ? TargetE : PCE+4`.
  2. `StallF`: hold `PCF`.
  3. Predicted taken: BTB target.
  4. Otherwise: `PCF+4`.
- A mispredict overrides `StallF`.
- Decode register priority, highest first:
  1. `FlushD | MispredictE`: bubble.
  2. `StallD`: hold.
  3. Otherwise: capture `InstrF`, `PCF`, `PCF+4`, the prediction bit and the predicted target.
- Bubble contents:
  - `InstrD = 32'h0000_0013` (addi x0,x0,0).
  - `PCD = 0`, `PCPlus4D = 0`.
  - `PredTakenD = 0`, `PredTargetD = 0`.
- BTB update occurs on `ResolveE`, indexed by `PCE[IDX+1:2]`:
  - Hit: `ctr` increments (saturates at 3) if `TakenE`, else decrements (saturates at 0). If `TakenE`, `target ← TargetE`.
  - Miss and `TakenE`: allocate the entry (overwrite). Set `valid=1`, tag from `PCE`, `target=TargetE`, `ctr=2'b10`.
  - Miss and not taken: no change.
- BTB updates ignore `StallF` and `StallD`.
- Reset:
  - `PCF = RESET_PC`.
  - Decode register holds the bubble.
  - All `valid = 0` and all `ctr = 2'b01`.
  - `MispredictE` depends only on its inputs.
- All PC arithmetic is modulo 2^32. `PCF+4` wraps from 0xFFFF_FFFC to 0.

## Timing
- `PCF` is registered.
- `InstrF` is sampled in the same cycle it is presented.
- Fetch→decode latency is 1 cycle.
- Mispredict redirect:
  - `MispredictE` is high in cycle t.
  - At t+1, `PCF` equals the corrected address and the decode register holds a bubble.
- BTB read/write to the same index in the same cycle: the lookup sees the pre-update contents. The update is visible from the next cycle.
- A stall released in cycle t: PC advances at the t edge per the normal priority.
- Reset asserted mid-operation overrides every other input at that edge. `ResolveE` is ignored during reset.

## Test plan
- Reset, sequential fetch:
  - Stimulus: hold `rst=0` for 2 cycles, then release with no resolves.
  - Required: `PCF` sequence 0, 4, 8, 12. `InstrD`/`PCD` trail by one cycle. `PredTakenD = 0` throughout.
- Stall/flush:
  - Stimulus: `StallF=StallD=1` at `PCF=8`.
  - Required: `PCF` holds 8 and the decode outputs hold.
  - Stimulus: `FlushD=StallD=1` together.
  - Required: `InstrD=0x13`, `PCD=0`.
- Train and predict:
  - Stimulus: resolve `PCE=0x10`, `TakenE=1`, `TargetE=0x40`, `PredTakenE=0`.
  - Required: `MispredictE=1`, next `PCF=0x40`, decode bubble.
  - Stimulus: later fetch reaches 0x10.
  - Required: next `PCF=0x40`, `PredTakenD=1`, `PredTargetD=0x40`.
- Counter hysteresis:
  - Stimulus: from `ctr=2'b10`, resolve 0x10 not-taken once.
  - Required: `ctr=2'b01`; next fetch of 0x10 predicts not-taken (`PCF` goes to 0x14).
  - Stimulus: two further taken resolves.
  - Required: predicts taken again.
- Mispredict beats stall:
  - Stimulus: `StallF=1`, `ResolveE=1`, `TakenE=0`, `PredTakenE=1`, `PCE=0x20`.
  - Required: next `PCF=0x24`, decode bubble.
- Tag alias:
  - Stimulus: with 0x10 trained, fetch `0x10 + 4*BTB_ENTRIES`.
  - Required: no prediction (tag miss), `PCF` advances by 4.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard controls, instruction memory, execute resolution and decode outputs.
// master = fetch stage, slave = surrounding pipeline.
interface fetch_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  StallF;
    logic                  StallD;
    logic                  FlushD;
    logic [31:0]           InstrF;
    logic                  ResolveE;
    logic [DATA_WIDTH-1:0] PCE;
    logic                  TakenE;
    logic [DATA_WIDTH-1:0] TargetE;
    logic                  PredTakenE;
    logic [DATA_WIDTH-1:0] PredTargetE;
    logic [DATA_WIDTH-1:0] PCF;
    logic [31:0]           InstrD;
    logic [DATA_WIDTH-1:0] PCD;
    logic [DATA_WIDTH-1:0] PCPlus4D;
    logic                  PredTakenD;
    logic [DATA_WIDTH-1:0] PredTargetD;
    logic                  MispredictE;

    modport master (
        input  StallF, StallD, FlushD, InstrF,
        input  ResolveE, PCE, TakenE, TargetE, PredTakenE, PredTargetE,
        output PCF, InstrD, PCD, PCPlus4D, PredTakenD, PredTargetD, MispredictE
    );

    modport slave (
        output StallF, StallD, FlushD, InstrF,
        output ResolveE, PCE, TakenE, TargetE, PredTakenE, PredTargetE,
        input  PCF, InstrD, PCD, PCPlus4D, PredTakenD, PredTargetD, MispredictE
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC register, direct-mapped BTB with 2-bit counters, fetch->decode register.
// Latency: 1 cycle fetch->decode; StallF/StallD hold, a mispredict overrides stalls and bubbles decode.
module fetch_stage #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    BTB_ENTRIES = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    localparam int          IDX   = $clog2(BTB_ENTRIES);
    localparam int          TAG_W = DATA_WIDTH - IDX - 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef logic [DATA_WIDTH-1:0] word_t;

    typedef struct packed {
        logic [31:0] instr;
        word_t       pc;
        word_t       pc_plus4;
        logic        pred_taken;
        word_t       pred_target;
    } dec_t;

    localparam dec_t BUBBLE = {NOP, {(3*DATA_WIDTH+1){1'b0}}};

    logic             btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
    word_t            btb_target [BTB_ENTRIES];
    logic [1:0]       btb_ctr    [BTB_ENTRIES];

    word_t          pcf_q, pc_next, pc_plus4_f, pred_target_f;
    logic [IDX-1:0] idx_f, idx_e;
    logic           hit_f, hit_e, pred_taken_f, mispredict;
    dec_t           dec_q, dec_next;

    assign pc_plus4_f    = pcf_q + word_t'(4);
    assign idx_f         = pcf_q[IDX+1:2];
    assign idx_e         = bus.PCE[IDX+1:2];
    assign hit_f         = btb_valid[idx_f] && (btb_tag[idx_f] == pcf_q[DATA_WIDTH-1:IDX+2]);
    assign hit_e         = btb_valid[idx_e] && (btb_tag[idx_e] == bus.PCE[DATA_WIDTH-1:IDX+2]);
    assign pred_taken_f  = hit_f && btb_ctr[idx_f][1];
    // Not-taken predictions carry the fall-through address as their target.
    assign pred_target_f = pred_taken_f ? btb_target[idx_f] : pc_plus4_f;

    assign mispredict = bus.ResolveE &
                        ((bus.TakenE != bus.PredTakenE) |
                         (bus.TakenE & (bus.TargetE != bus.PredTargetE)));

    always_comb begin
        pc_next = pc_plus4_f;
        if (mispredict)
            pc_next = bus.TakenE ? bus.TargetE : bus.PCE + word_t'(4);
        else if (bus.StallF)
            pc_next = pcf_q;
        else if (pred_taken_f)
            pc_next = btb_target[idx_f];
    end

    always_comb begin
        dec_next = dec_q;
        if (bus.FlushD || mispredict) begin
            dec_next = BUBBLE;
        end else if (!bus.StallD) begin
            dec_next.instr       = bus.InstrF;
            dec_next.pc          = pcf_q;
            dec_next.pc_plus4    = pc_plus4_f;
            dec_next.pred_taken  = pred_taken_f;
            dec_next.pred_target = pred_target_f;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pcf_q <= RESET_PC;
            dec_q <= BUBBLE;
        end else begin
            pcf_q <= pc_next;
            dec_q <= dec_next;
        end
    end

    // Valid and counter state; lookups this cycle still see the old values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                btb_ctr[i]   <= 2'b01;
            end
        end else if (bus.ResolveE) begin
            if (hit_e) begin
                if (bus.TakenE) begin
                    if (btb_ctr[idx_e] != 2'b11) btb_ctr[idx_e] <= btb_ctr[idx_e] + 2'b01;
                end else begin
                    if (btb_ctr[idx_e] != 2'b00) btb_ctr[idx_e] <= btb_ctr[idx_e] - 2'b01;
                end
            end else if (bus.TakenE) begin
                btb_valid[idx_e] <= 1'b1;
                btb_ctr[idx_e]   <= 2'b10;
            end
        end
    end

    // Tag rewrite on a taken hit stores the same tag, so every taken resolve can write both fields.
    always_ff @(posedge clk) begin
        if (rst && bus.ResolveE && bus.TakenE) begin
            btb_tag[idx_e]    <= bus.PCE[DATA_WIDTH-1:IDX+2];
            btb_target[idx_e] <= bus.TargetE;
        end
    end

    assign bus.PCF         = pcf_q;
    assign bus.InstrD      = dec_q.instr;
    assign bus.PCD         = dec_q.pc;
    assign bus.PCPlus4D    = dec_q.pc_plus4;
    assign bus.PredTakenD  = dec_q.pred_taken;
    assign bus.PredTargetD = dec_q.pred_target;
    assign bus.MispredictE = mispredict;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_stage;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_stage_if #(.DATA_WIDTH(32)) ifc ();

    fetch_stage #(.DATA_WIDTH(32), .BTB_ENTRIES(N), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .bus(ifc)
    );

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    assign ifc.InstrF = imem(ifc.PCF);

    int n_cmp = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [31:0] m_pcf, m_instrd, m_pcd, m_pcp4d, m_ptgtd;
    logic        m_ptd;
    bit          b_valid [N];
    logic [31:0] b_tag [N];
    logic [31:0] b_tgt [N];
    int          b_ctr [N];
    logic        exp_mis, obs_mis;

    function automatic logic model_mis();
        if (!ifc.ResolveE) return 1'b0;
        if (ifc.TakenE != ifc.PredTakenE) return 1'b1;
        return ifc.TakenE && (ifc.TargetE != ifc.PredTargetE);
    endfunction

    task automatic model_edge();
        int          fi, ei;
        logic        pt, mis, ehit;
        logic [31:0] pnext;
        if (!rst) begin
            m_pcf = 32'h0;
            m_instrd = 32'h13; m_pcd = 0; m_pcp4d = 0; m_ptd = 0; m_ptgtd = 0;
            for (int i = 0; i < N; i++) begin b_valid[i] = 0; b_ctr[i] = 1; end
        end else begin
            fi = int'((m_pcf / 4) % N);
            pt = b_valid[fi] && (b_tag[fi] == m_pcf / (4 * N)) && (b_ctr[fi] >= 2);
            mis = model_mis();
            if (mis) pnext = ifc.TakenE ? ifc.TargetE : ifc.PCE + 32'd4;
            else if (ifc.StallF) pnext = m_pcf;
            else if (pt) pnext = b_tgt[fi];
            else pnext = m_pcf + 32'd4;
            if (ifc.FlushD || mis) begin
                m_instrd = 32'h13; m_pcd = 0; m_pcp4d = 0; m_ptd = 0; m_ptgtd = 0;
            end else if (!ifc.StallD) begin
                m_instrd = imem(m_pcf); m_pcd = m_pcf; m_pcp4d = m_pcf + 32'd4;
                m_ptd = pt; m_ptgtd = pt ? b_tgt[fi] : m_pcf + 32'd4;
            end
            if (ifc.ResolveE) begin
                ei = int'((ifc.PCE / 4) % N);
                ehit = b_valid[ei] && (b_tag[ei] == ifc.PCE / (4 * N));
                if (ehit) begin
                    if (ifc.TakenE) begin
                        b_ctr[ei] = (b_ctr[ei] < 3) ? b_ctr[ei] + 1 : 3;
                        b_tgt[ei] = ifc.TargetE;
                    end else begin
                        b_ctr[ei] = (b_ctr[ei] > 0) ? b_ctr[ei] - 1 : 0;
                    end
                end else if (ifc.TakenE) begin
                    b_valid[ei] = 1; b_tag[ei] = ifc.PCE / (4 * N);
                    b_tgt[ei] = ifc.TargetE; b_ctr[ei] = 2;
                end
            end
            m_pcf = pnext;
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return at the next falling edge.
    task automatic step(input bit r, sf, sd, fd, res, input logic [31:0] pce,
                        input bit tk, input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
        rst = r; ifc.StallF = sf; ifc.StallD = sd; ifc.FlushD = fd;
        ifc.ResolveE = res; ifc.PCE = pce; ifc.TakenE = tk; ifc.TargetE = tgt;
        ifc.PredTakenE = ptk; ifc.PredTargetE = ptgt;
        #1;
        exp_mis = model_mis();
        obs_mis = ifc.MispredictE;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input bit sf, sd, fd);
        step(1, sf, sd, fd, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask

    // Redirect fetch via a not-taken mispredict of the preceding PC.
    task automatic steer(input logic [31:0] addr);
        step(1, 0, 0, 0, 1, addr - 32'd4, 0, 32'h0, 1, 32'h0);
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        n_cmp++; if (ifc.PCF !== 32'h0) begin n_fail++; $display("FAIL reset_pcf: got %h want 0", ifc.PCF); end
        n_cmp++; if (ifc.InstrD !== 32'h13) begin n_fail++; $display("FAIL reset_instrd: got %h want 13", ifc.InstrD); end
        n_cmp++; if (ifc.PCD !== 32'h0 || ifc.PCPlus4D !== 32'h0) begin n_fail++; $display("FAIL reset_pcd: got %h/%h want 0/0", ifc.PCD, ifc.PCPlus4D); end
        n_cmp++; if (ifc.PredTakenD !== 1'b0 || ifc.PredTargetD !== 32'h0) begin n_fail++; $display("FAIL reset_pred: got %b/%h want 0/0", ifc.PredTakenD, ifc.PredTargetD); end
        for (int k = 1; k <= 3; k++) begin
            idle(0, 0, 0);
            n_cmp++; if (ifc.PCF !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_pcf[%0d]: got %h want %h", k, ifc.PCF, 4 * k); end
            n_cmp++; if (ifc.PCD !== 32'(4 * (k - 1)) || ifc.InstrD !== imem(32'(4 * (k - 1)))) begin n_fail++; $display("FAIL seq_dec[%0d]: got %h/%h", k, ifc.PCD, ifc.InstrD); end
            n_cmp++; if (ifc.PredTakenD !== 1'b0) begin n_fail++; $display("FAIL seq_pred[%0d]: got %b want 0", k, ifc.PredTakenD); end
        end
    endtask

    task automatic test_stall_flush();
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        idle(0, 0, 0);
        idle(0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            idle(1, 1, 0);
            n_cmp++; if (ifc.PCF !== 32'h8) begin n_fail++; $display("FAIL stall_pcf: got %h want 8", ifc.PCF); end
            n_cmp++; if (ifc.PCD !== 32'h4 || ifc.InstrD !== imem(32'h4)) begin n_fail++; $display("FAIL stall_dec: got %h/%h want 4/%h", ifc.PCD, ifc.InstrD, imem(32'h4)); end
        end
        idle(1, 1, 1);
        n_cmp++; if (ifc.InstrD !== 32'h13 || ifc.PCD !== 32'h0) begin n_fail++; $display("FAIL flush_dec: got %h/%h want 13/0", ifc.InstrD, ifc.PCD); end
        idle(0, 0, 0);
        n_cmp++; if (ifc.PCF !== 32'hC || ifc.PCD !== 32'h8) begin n_fail++; $display("FAIL release: got %h/%h want c/8", ifc.PCF, ifc.PCD); end
    endtask

    task automatic test_train();
        step(1, 0, 0, 0, 1, 32'h10, 1, 32'h40, 0, 32'h0);
        n_cmp++; if (obs_mis !== 1'b1) begin n_fail++; $display("FAIL train_mis: got %b want 1", obs_mis); end
        n_cmp++; if (ifc.PCF !== 32'h40 || ifc.InstrD !== 32'h13) begin n_fail++; $display("FAIL train_redirect: got %h/%h want 40/13", ifc.PCF, ifc.InstrD); end
        steer(32'h10);
        idle(0, 0, 0);
        n_cmp++; if (ifc.PCF !== 32'h40) begin n_fail++; $display("FAIL predict_pcf: got %h want 40", ifc.PCF); end
        n_cmp++; if (ifc.PredTakenD !== 1'b1 || ifc.PredTargetD !== 32'h40 || ifc.PCD !== 32'h10) begin n_fail++; $display("FAIL predict_dec: got %b/%h/%h want 1/40/10", ifc.PredTakenD, ifc.PredTargetD, ifc.PCD); end
    endtask

    task automatic test_hysteresis();
        step(1, 0, 0, 0, 1, 32'h10, 0, 32'h0, 1, 32'h40);
        n_cmp++; if (ifc.PCF !== 32'h14) begin n_fail++; $display("FAIL hyst_redirect: got %h want 14", ifc.PCF); end
        steer(32'h10);
        idle(0, 0, 0);
        n_cmp++; if (ifc.PCF !== 32'h14 || ifc.PredTakenD !== 1'b0) begin n_fail++; $display("FAIL hyst_weak: got %h/%b want 14/0", ifc.PCF, ifc.PredTakenD); end
        for (int k = 0; k < 2; k++) begin
            step(1, 0, 0, 0, 1, 32'h10, 1, 32'h40, 1, 32'h40);
            n_cmp++; if (obs_mis !== 1'b0) begin n_fail++; $display("FAIL hyst_mis[%0d]: got %b want 0", k, obs_mis); end
        end
        steer(32'h10);
        idle(0, 0, 0);
        n_cmp++; if (ifc.PCF !== 32'h40 || ifc.PredTakenD !== 1'b1) begin n_fail++; $display("FAIL hyst_strong: got %h/%b want 40/1", ifc.PCF, ifc.PredTakenD); end
    endtask

    task automatic test_mispredict_stall();
        step(1, 1, 0, 0, 1, 32'h20, 0, 32'h0, 1, 32'h0);
        n_cmp++; if (obs_mis !== 1'b1) begin n_fail++; $display("FAIL mstall_mis: got %b want 1", obs_mis); end
        n_cmp++; if (ifc.PCF !== 32'h24 || ifc.InstrD !== 32'h13 || ifc.PCD !== 32'h0) begin n_fail++; $display("FAIL mstall: got %h/%h/%h want 24/13/0", ifc.PCF, ifc.InstrD, ifc.PCD); end
    endtask

    task automatic test_alias();
        steer(32'h10 + 32'(4 * N));
        idle(0, 0, 0);
        n_cmp++; if (ifc.PCF !== 32'h54 || ifc.PredTakenD !== 1'b0) begin n_fail++; $display("FAIL alias: got %h/%b want 54/0", ifc.PCF, ifc.PredTakenD); end
    endtask

    task automatic test_wrap();
        steer(32'hFFFF_FFFC);
        idle(0, 0, 0);
        n_cmp++; if (ifc.PCF !== 32'h0 || ifc.PCD !== 32'hFFFF_FFFC || ifc.PCPlus4D !== 32'h0) begin n_fail++; $display("FAIL wrap: got %h/%h/%h want 0/fffffffc/0", ifc.PCF, ifc.PCD, ifc.PCPlus4D); end
    endtask

    task automatic test_reset_override();
        step(0, 1, 0, 0, 1, 32'h10, 1, 32'h80, 0, 32'h0);
        n_cmp++; if (ifc.PCF !== 32'h0 || ifc.InstrD !== 32'h13) begin n_fail++; $display("FAIL rst_override: got %h/%h want 0/13", ifc.PCF, ifc.InstrD); end
        steer(32'h10);
        idle(0, 0, 0);
        n_cmp++; if (ifc.PCF !== 32'h14 || ifc.PredTakenD !== 1'b0) begin n_fail++; $display("FAIL rst_btb_clear: got %h/%b want 14/0", ifc.PCF, ifc.PredTakenD); end
    endtask

    task automatic test_random();
        logic [31:0] pce, tgt, ptgt;
        for (int k = 0; k < 600; k++) begin
            pce  = 32'($urandom_range(0, 63)) * 32'd4;
            tgt  = 32'($urandom_range(0, 63)) * 32'd4;
            ptgt = ($urandom_range(0, 1) == 0) ? tgt : 32'($urandom_range(0, 63)) * 32'd4;
            step($urandom_range(0, 59) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, pce,
                 1'($urandom_range(0, 1)), tgt, 1'($urandom_range(0, 1)), ptgt);
            n_cmp++; if (obs_mis !== exp_mis) begin n_fail++; $display("FAIL rnd_mis[%0d]: got %b want %b", k, obs_mis, exp_mis); end
            n_cmp++; if (ifc.PCF !== m_pcf) begin n_fail++; $display("FAIL rnd_pcf[%0d]: got %h want %h", k, ifc.PCF, m_pcf); end
            n_cmp++; if (ifc.InstrD !== m_instrd || ifc.PCD !== m_pcd || ifc.PCPlus4D !== m_pcp4d) begin n_fail++; $display("FAIL rnd_dec[%0d]: got %h/%h/%h want %h/%h/%h", k, ifc.InstrD, ifc.PCD, ifc.PCPlus4D, m_instrd, m_pcd, m_pcp4d); end
            n_cmp++; if (ifc.PredTakenD !== m_ptd || ifc.PredTargetD !== m_ptgtd) begin n_fail++; $display("FAIL rnd_pred[%0d]: got %b/%h want %b/%h", k, ifc.PredTakenD, ifc.PredTargetD, m_ptd, m_ptgtd); end
        end
    endtask

    initial begin
        test_reset();
        test_stall_flush();
        test_train();
        test_hysteresis();
        test_mispredict_stall();
        test_alias();
        test_wrap();
        test_reset_override();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
